// File: rtl/cim_wbank_loader_pkg.sv
// Shared types, default sizes and index helpers for the CIM weight-bank loader.
// Optional readback port is enabled with `define CIM_WBANK_RDBK_EN.
package cim_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam int DEF_NUM_BANKS = 2;
  localparam int DEF_ROWS      = 8;
  localparam int DEF_COL_W     = 12;
  localparam int DEF_DATA_W    = 2 * DEF_COL_W;

  // Width of an index into n items; never collapses to zero bits.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_BANK_W = ptr_w(DEF_NUM_BANKS);
  localparam int DEF_ROW_W  = ptr_w(DEF_ROWS);
  localparam int DEF_LEN_W  = $clog2(DEF_ROWS) + 1;

  // LSB of bank/row field on the flat wb_a/wb_b buses.
  function automatic int bus_idx(input int bank, input int row, input int rows, input int col_w);
    return (bank * rows + row) * col_w;
  endfunction

endpackage

// File: rtl/cim_wbank_loader_if.sv
// Burst-command plus valid/ready data stream between the weight DMA and the loader.
interface cim_wbank_loader_if
  import cim_pkg::*;
#(
  parameter int BANK_W = DEF_BANK_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_row;
  logic [LEN_W-1:0]  cmd_len;
  logic              d_valid;
  logic              d_ready;
  logic [DATA_W-1:0] d_data;

  modport master (
    output cmd_valid, cmd_bank, cmd_row, cmd_len, d_valid, d_data,
    input  cmd_ready, d_ready
  );

  modport slave (
    input  cmd_valid, cmd_bank, cmd_row, cmd_len, d_valid, d_data,
    output cmd_ready, d_ready
  );
endinterface

// File: rtl/cim_wbank_loader_row_reg.sv
// One weight row: {b, a} fields held inverted, erased (all ones) on reset or clear.
module cim_row_reg #(
  parameter int COL_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic               i_clr,
  input  logic [2*COL_W-1:0] i_data,
  output logic [COL_W-1:0]   o_a,
  output logic [COL_W-1:0]   o_b
);

  logic [2*COL_W-1:0] r_row;

  // NOTE: this storage carries an async reset because the erased value is
  // architecturally visible after reset; plain RAM arrays would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_row <= '1;
    else if (i_clr) r_row <= '1;
    else if (i_we)  r_row <= ~i_data;
  end

  assign o_a = r_row[COL_W-1:0];
  assign o_b = r_row[2*COL_W-1:COL_W];

endmodule

// File: rtl/cim_wbank_loader.sv
// Clocked NUM_BANKS x ROWS weight store fed by burst command + data stream.
// Define CIM_WBANK_RDBK_EN to add a registered readback port.
module cim_wbank_loader
  import cim_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int ROWS      = 8,
  parameter int COL_W     = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cim_wbank_loader_if.slave            bus,
  input  logic                         clr,
  output logic [NUM_BANKS*ROWS*COL_W-1:0] wb_a,
  output logic [NUM_BANKS*ROWS*COL_W-1:0] wb_b,
  output logic                         busy,
  output logic                         done,
  output logic                         err
`ifdef CIM_WBANK_RDBK_EN
  ,
  input  logic                         rd_en,
  input  logic [ptr_w(NUM_BANKS)-1:0]  rd_bank,
  input  logic [ptr_w(ROWS)-1:0]       rd_row,
  output logic [2*COL_W-1:0]           rd_data
`endif
);

  localparam int DATA_W = 2 * COL_W;
  localparam int BANK_W = ptr_w(NUM_BANKS);
  localparam int ROW_W  = ptr_w(ROWS);
  localparam int LEN_W  = $clog2(ROWS) + 1;

  state_t            r_state;
  logic [ROW_W-1:0]  r_ptr;
  logic [LEN_W-1:0]  r_rem;
  logic [BANK_W-1:0] r_bank;
  logic              r_cmd_ready, r_d_ready, r_busy, r_done, r_err;

  logic w_beat, w_cmd_bad, w_clr_all;
  logic [ROW_W-1:0] w_ptr_next;

  assign w_beat     = r_d_ready && bus.d_valid;
  assign w_clr_all  = (r_state == IDLE) && clr;
  assign w_cmd_bad  = (bus.cmd_len == '0) || (int'(bus.cmd_len) > ROWS) ||
                      (int'(bus.cmd_bank) >= NUM_BANKS);
  assign w_ptr_next = (r_ptr == ROW_W'(ROWS - 1)) ? '0 : r_ptr + 1'b1;

  // NOTE: all FSM state and outputs use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_bank      <= '0;
      r_cmd_ready <= 1'b1;
      r_d_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // clr takes priority; a simultaneous command is left for a retry.
          if (!clr && bus.cmd_valid) begin
            if (w_cmd_bad) begin
              r_err <= 1'b1;
            end else begin
              r_ptr       <= bus.cmd_row;
              r_rem       <= bus.cmd_len;
              r_bank      <= bus.cmd_bank;
              r_state     <= LOAD;
              r_cmd_ready <= 1'b0;
              r_d_ready   <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (clr) r_err <= 1'b1;
          if (w_beat) begin
            r_ptr <= w_ptr_next;
            r_rem <= r_rem - 1'b1;
            if (r_rem == LEN_W'(1)) begin
              r_state   <= DONE;
              r_d_ready <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        DONE: begin
          if (clr) r_err <= 1'b1;
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.d_ready   = r_d_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

`ifdef CIM_WBANK_RDBK_EN
  logic [DATA_W-1:0] w_rows [NUM_BANKS*ROWS];
`endif

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [COL_W-1:0] w_a, w_b;
      logic             w_we;

      assign w_we = w_beat && (r_bank == BANK_W'(k)) && (r_ptr == ROW_W'(r));

      cim_row_reg #(.COL_W(COL_W)) u_row (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we),
        .i_clr  (w_clr_all),
        .i_data (bus.d_data),
        .o_a    (w_a),
        .o_b    (w_b)
      );

      assign wb_a[bus_idx(k, r, ROWS, COL_W) +: COL_W] = w_a;
      assign wb_b[bus_idx(k, r, ROWS, COL_W) +: COL_W] = w_b;
`ifdef CIM_WBANK_RDBK_EN
      assign w_rows[k*ROWS+r] = {w_b, w_a};
`endif
    end
  end

`ifdef CIM_WBANK_RDBK_EN
  logic [DATA_W-1:0] r_rd_data;

  // Reads see pre-edge storage, so a same-cycle write returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_rd_data <= '0;
    else if (rd_en) r_rd_data <= ~w_rows[int'(rd_bank)*ROWS + int'(rd_row)];
  end

  assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_cim_wbank_loader.sv
// Scoreboard bench for cim_wbank_loader: done/err pulses are checked by a monitor.
module tb_cim_wbank_loader;
  import cim_pkg::*;

  localparam int NB = 2;
  localparam int NR = 8;
  localparam int CW = 12;
  localparam int FW = NB * NR * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [FW-1:0] wb_a, wb_b;
  logic busy, done, err;

  always #5 clk = ~clk;

  cim_wbank_loader_if #(.BANK_W(1), .ROW_W(3), .LEN_W(4), .DATA_W(24)) bus ();

`ifdef CIM_WBANK_RDBK_EN
  logic        rd_en = 1'b0;
  logic [0:0]  rd_bank = '0;
  logic [2:0]  rd_row = '0;
  logic [23:0] rd_data;
`endif

  cim_wbank_loader #(.NUM_BANKS(NB), .ROWS(NR), .COL_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .clr   (clr),
    .wb_a  (wb_a),
    .wb_b  (wb_b),
    .busy  (busy),
    .done  (done),
    .err   (err)
`ifdef CIM_WBANK_RDBK_EN
    ,
    .rd_en   (rd_en),
    .rd_bank (rd_bank),
    .rd_row  (rd_row),
    .rd_data (rd_data)
`endif
  );

  typedef enum {EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [FW-1:0] a;
    logic [FW-1:0] b;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  logic [CW-1:0] m_a [NB][NR];
  logic [CW-1:0] m_b [NB][NR];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] flat_a();
    logic [FW-1:0] v;
    for (int k = 0; k < NB; k++)
      for (int r = 0; r < NR; r++) v[(k*NR+r)*CW +: CW] = m_a[k][r];
    return v;
  endfunction

  function automatic logic [FW-1:0] flat_b();
    logic [FW-1:0] v;
    for (int k = 0; k < NB; k++)
      for (int r = 0; r < NR; r++) v[(k*NR+r)*CW +: CW] = m_b[k][r];
    return v;
  endfunction

  task automatic model_erase();
    for (int k = 0; k < NB; k++)
      for (int r = 0; r < NR; r++) begin
        m_a[k][r] = '1;
        m_b[k][r] = '1;
      end
  endtask

  task automatic push(input ev_kind_t kind);
    ev_t e;
    e.kind = kind;
    e.a = flat_a();
    e.b = flat_b();
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input int bank, input int row, input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_bank  = 1'(bank);
    bus.cmd_row   = 3'(row);
    bus.cmd_len   = 4'(len);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Streams beats into an accepted burst, then steps through DONE back to IDLE.
  task automatic beats(input int bank, input int row, input logic [23:0] d[$]);
    for (int i = 0; i < d.size(); i++) begin
      int r;
      r = (row + i) % NR;
      m_a[bank][r] = ~d[i][11:0];
      m_b[bank][r] = ~d[i][23:12];
      if (i == d.size() - 1) push(EV_DONE);
      bus.d_valid = 1'b1;
      bus.d_data  = d[i];
      tick();
    end
    bus.d_valid = 1'b0;
    tick();
  endtask

  // Monitor: every done/err pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got done=%0b err=%0b expected none", done, err);
      end else begin
        mon_e = sb.pop_front();
        check("event_kind", FW'({done, err}), (mon_e.kind == EV_DONE) ? FW'(2'b10) : FW'(2'b01));
        check("event_wb_a", wb_a, mon_e.a);
        check("event_wb_b", wb_b, mon_e.b);
      end
    end
  end

  initial begin
    logic [23:0] d[$];
    int guard;

    bus.cmd_valid = 1'b0;
    bus.cmd_bank  = '0;
    bus.cmd_row   = '0;
    bus.cmd_len   = '0;
    bus.d_valid   = 1'b0;
    bus.d_data    = '0;
    model_erase();

    // 1. reset state
    #12;
    check("rst_wb_a", wb_a, {FW{1'b1}});
    check("rst_wb_b", wb_b, {FW{1'b1}});
    check("rst_ctrl", FW'({bus.cmd_ready, bus.d_ready, busy, done, err}), FW'(5'b10000));
    tick();
    rst_n = 1'b1;
    tick();

    // 2. full bank0 burst
    d = {};
    for (int i = 0; i < 8; i++) d.push_back({12'h100 + 12'(i), 12'hA00 + 12'(i)});
    cmd(0, 0, 8);
    check("load_busy", FW'({busy, bus.cmd_ready, bus.d_ready}), FW'(3'b101));
    beats(0, 0, d);
    check("s2_bank0_a", FW'(wb_a[95:0]), FW'(96'h5f85f95fa5fb5fc5fd5fe5ff));
    check("s2_bank0_b", FW'(wb_b[95:0]), FW'(96'hef8ef9efaefbefcefdefeeff));
    check("s2_bank1_a", FW'(wb_a[191:96]), FW'({96{1'b1}}));
    check("s2_idle", FW'({busy, done, bus.cmd_ready}), FW'(3'b001));

    // 3. wrap across the end of bank1
    cmd(1, 6, 3);
    beats(1, 6, '{24'h111222, 24'h333444, 24'h555666});
    check("s3_bank1_a", FW'(wb_a[191:96]), FW'(96'hbbbdddfffffffffffffff999));
    check("s3_bank1_b", FW'(wb_b[191:96]), FW'(96'hccceeefffffffffffffffaaa));

    // 4. backpressure gap, then overwrite one row
    cmd(0, 3, 1);
    for (int g = 0; g < 4; g++) begin
      tick();
      check("s4_gap_a", wb_a, flat_a());
      check("s4_gap_ready", FW'(bus.d_ready), FW'(1'b1));
    end
    beats(0, 3, '{24'hDEADBE});
    check("s4_bank0_a", FW'(wb_a[95:0]), FW'(96'h5f85f95fa5fb2415fd5fe5ff));
    check("s4_bank0_b", FW'(wb_b[95:0]), FW'(96'hef8ef9efaefb215efdefeeff));

    // 5. illegal commands, then clr during a load
    push(EV_ERR);
    cmd(0, 0, 0);
    check("s5_len0_busy", FW'({busy, bus.cmd_ready}), FW'(2'b01));
    tick();
    push(EV_ERR);
    cmd(1, 2, 9);
    check("s5_len9_busy", FW'({busy, bus.cmd_ready}), FW'(2'b01));
    tick();
    check("s5_store_a", wb_a, flat_a());
    cmd(1, 0, 2);
    push(EV_ERR);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("s5_clr_load_busy", FW'(busy), FW'(1'b1));
    beats(1, 0, '{24'h0F00F0, 24'hA5A5A5});
    check("s5_after_a", wb_a, flat_a());
    check("s5_after_b", wb_b, flat_b());

    // 6. reset part way through a burst
    cmd(0, 0, 5);
    bus.d_valid = 1'b1;
    bus.d_data  = 24'h123123;
    tick();
    tick();
    bus.d_valid = 1'b0;
    rst_n = 1'b0;
    model_erase();
    #1;
    check("s6_rst_a", wb_a, {FW{1'b1}});
    check("s6_rst_ctrl", FW'({bus.cmd_ready, bus.d_ready, busy}), FW'(3'b100));
    tick();
    rst_n = 1'b1;
    tick();

    // 6b. clr in IDLE after a load; simultaneous command is refused
    cmd(1, 2, 1);
    beats(1, 2, '{24'h123456});
    check("s6_loaded_a", wb_a, flat_a());
    clr = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 4'd1;
    tick();
    clr = 1'b0;
    bus.cmd_valid = 1'b0;
    model_erase();
    check("s6_clr_a", wb_a, {FW{1'b1}});
    check("s6_clr_b", wb_b, {FW{1'b1}});
    check("s6_clr_cmd", FW'({busy, bus.cmd_ready}), FW'(2'b01));

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending events expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cim_wbank_loader.md
Name: cim_wbank_loader

Overview:
Parametrised, clocked successor to the combinational two-bank CIM weight array.
- Stores NUM_BANKS x ROWS rows of weights. Each row holds two COL_W-bit fields, driven out inverted on the flat wb_a/wb_b buses that feed the CIM compute columns.
- Writes arrive as a burst command followed by a valid/ready data stream. An internal FSM auto-increments the row pointer, with wrap.
- Sits between the weight DMA/host interface and the CIM macro columns.

Parameters:
NUM_BANKS, 2, number of weight banks
ROWS, 8, rows per bank
COL_W, 12, bits per field; data word is 2*COL_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  high in IDLE only
cmd_bank  in  max(1,$clog2(NUM_BANKS))  target bank
cmd_row  in  $clog2(ROWS)  first row
cmd_len  in  $clog2(ROWS)+1  beats, legal range 1..ROWS
d_valid  in  1  data beat valid
d_ready  out  1  high in LOAD only
d_data  in  2*COL_W  {b_field, a_field}
clr  in  1  erase all storage (IDLE only)
wb_a  out  NUM_BANKS*ROWS*COL_W  inverted a-fields; bank k row r at [(k*ROWS+r)*COL_W +: COL_W]
wb_b  out  NUM_BANKS*ROWS*COL_W  inverted b-fields, same mapping
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at burst completion
err  out  1  one-cycle pulse on illegal command or clr while busy

Behaviour:
- Reset (async, rst_n=0):
  - All storage = all ones (erased).
  - State = IDLE; cmd_ready=1; d_ready=busy=done=err=0.
- Storage write on handshake: row <= {~d_data[2*COL_W-1:COL_W], ~d_data[COL_W-1:0]} (b, a). wb_a/wb_b change the cycle after the handshake edge.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - cmd_valid=1 with cmd_len==0, cmd_len>ROWS or cmd_bank>=NUM_BANKS -> err pulse next cycle; stay IDLE; storage untouched.
  - Legal command -> ptr=cmd_row, rem=cmd_len, bank latched; go to LOAD.
  - clr=1 with no cmd_valid -> all rows set to ones next cycle.
  - clr=1 and cmd_valid=1 in the same cycle -> clr wins; command is not accepted (cmd_ready stays 1, so the host retries).
- LOAD:
  - d_ready=1. Each d_valid&d_ready writes row ptr, then ptr=(ptr+1) mod ROWS and rem--.
  - No write without a handshake; gaps in d_valid are legal.
  - Beat with rem==1 -> go to DONE.
  - clr in LOAD is ignored and raises an err pulse.
  - cmd_valid is ignored (cmd_ready=0).
- DONE: done=1 for exactly one cycle; d_ready=0; then IDLE.
- Minimum burst occupancy: 1 (cmd) + len (beats) + 1 (DONE) cycles.
- Reset mid-LOAD: storage erased, partial burst discarded.

Optional Feature:
CIM_WBANK_RDBK_EN
- Defined: adds ports rd_en (in, 1), rd_bank, rd_row and rd_data (out, 2*COL_W). rd_data is registered, 1-cycle latency, and returns the un-inverted stored word. A read of the row being written in the same cycle returns the old value. rd_data resets to 0 and holds its value when rd_en=0.
- Undefined: these ports and that logic are absent.

Decomposition:
- Package cim_pkg: state enum (IDLE/LOAD/DONE), localparams for field width, data width and pointer widths, plus a helper function for the flat-bus index.
- One sub-module, cim_row_reg: one row of 2*COL_W flops with async reset to ones, a write enable, a clear and inverted storage. Instantiated NUM_BANKS*ROWS times via generate.

Test Plan:
All scenarios use the defaults (NUM_BANKS=2, ROWS=8, COL_W=12).
1. Reset -> wb_a = wb_b = 192'hfff...f; cmd_ready=1, busy=0.
2. cmd bank0 row0 len8, beats {12'h100+i, 12'hA00+i}, i=0..7 -> bank0 wb_a = 96'h5f85f95fa5fb5fc5fd5fe5ff, bank0 wb_b = 96'hef8ef9efaefbefcefdefeeff, bank1 unchanged (all ones); done pulses exactly once, the cycle after beat 7.
3. Wrap: cmd bank1 row6 len3, beats 24'h111222, 24'h333444, 24'h555666 -> bank1 a-fields row6=DDD, row7=BBB, row0=999; other bank1 rows FFF.
4. Backpressure/overwrite: cmd bank0 row3 len1, hold d_valid low 4 cycles then 24'hDEADBE -> no change during the gap; then bank0 row3 a=241, b=215; all other rows keep the values from scenario 2.
5. Illegal commands: cmd_len=0, then cmd_len=9 -> err pulse each, storage unchanged, busy stays 0. clr during LOAD -> err pulse, load continues.
6. Reset asserted after 2 of 5 beats -> storage all ones, IDLE, no done. Then clr in IDLE after a load -> all ones next cycle.
